// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-port memory arbiter: owner tag encoding,
// the `last` winner encoding and the deepest supported memory latency.
package mem_arbiter2_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } own_t;

   localparam int   LAT_MAX = 4;

   localparam logic LAST_I  = 1'b0;
   localparam logic LAST_D  = 1'b1;

   // Tag entering the return pipeline for the transfer happening this cycle.
   function automatic own_t push_tag(input logic iack, input logic dack, input logic dwe);
      own_t tag;
      tag = OWN_NONE;
      if (iack) begin
         tag = OWN_I;
      end else if (dack && !dwe) begin
         tag = OWN_D;
      end
      return tag;
   endfunction

endpackage

// File: rtl/mem_arbiter2_if.sv
// Bundle of the instruction port, data port and memory port around the arbiter.
// master = core + RAM side, slave = arbiter.
interface mem_arbiter2_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic              ireq;
   logic [AW-1:0]     iaddr;
   logic              iack;
   logic [DW-1:0]     idata;
   logic              ivalid;

   logic              dreq;
   logic              dwe;
   logic [DW/8-1:0]   dbe;
   logic [AW-1:0]     daddr;
   logic [DW-1:0]     dwdata;
   logic              dlock;
   logic              dack;
   logic [DW-1:0]     drdata;
   logic              dvalid;

   logic              men;
   logic              mwe;
   logic [DW/8-1:0]   mbe;
   logic [AW-1:0]     maddr;
   logic [DW-1:0]     mwdata;
   logic [DW-1:0]     mrdata;
   logic [1:0]        owner;

   modport master (
      output ireq, iaddr, dreq, dwe, dbe, daddr, dwdata, dlock, mrdata,
      input  iack, idata, ivalid, dack, drdata, dvalid,
      input  men, mwe, mbe, maddr, mwdata, owner
   );

   modport slave (
      input  ireq, iaddr, dreq, dwe, dbe, daddr, dwdata, dlock, mrdata,
      output iack, idata, ivalid, dack, drdata, dvalid,
      output men, mwe, mbe, maddr, mwdata, owner
   );
endinterface

// File: rtl/mem_arbiter2_tag_pipe.sv
// LAT-deep shift register of owner tags; the tag leaving the last stage says
// who owns the memory read data currently on the bus.
module arb_tag_pipe
   import mem_arbiter2_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  own_t tag_in,
   output own_t tag_out
);

   own_t stage_reg  [LAT];
   own_t stage_next [LAT];

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_next[gi] = tag_in;
         end else begin : g_body
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int k = 0; k < LAT; k++) begin
         stage_reg[k] <= rst ? OWN_NONE : stage_next[k];
      end
   end

   assign tag_out = stage_reg[LAT-1];

endmodule

// File: rtl/mem_arbiter2.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; otherwise data wins.
module mem_arbiter2
   import mem_arbiter2_pkg::*;
#(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   mem_arbiter2_if.slave  bus
);

   localparam int BW      = DW / 8;
   // Out-of-range latencies are pulled into the supported 1..LAT_MAX window.
   localparam int LAT_EFF = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

   logic          last_reg, last_next;
   logic          locked_reg, locked_next;
   logic          lock_hold;
   logic          ireq_eff;
   logic          pick_i;
   logic          iack, dack;
   own_t          tag_in, tag_out;
   logic [AW-1:0] maddr_mux;
   logic [BW-1:0] mbe_mux;

   always_comb begin
      // A held lock only blocks fetch while the data port keeps asking for it.
      lock_hold = locked_reg & bus.dlock;
      ireq_eff  = bus.ireq & ~lock_hold;
`ifdef ARB_ROUND_ROBIN_EN
      pick_i    = (last_reg == LAST_D);
`else
      pick_i    = 1'b0;
`endif
      iack      = ~rst & ireq_eff & (~bus.dreq | pick_i);
      dack      = ~rst & bus.dreq & (~ireq_eff | ~pick_i);

      last_next = last_reg;
      if (iack) begin
         last_next = LAST_I;
      end else if (dack) begin
         last_next = LAST_D;
      end

      locked_next = locked_reg;
      if (dack && bus.dlock) begin
         locked_next = 1'b1;
      end else if (!bus.dlock) begin
         locked_next = 1'b0;
      end

      tag_in    = push_tag(iack, dack, bus.dwe);
      maddr_mux = iack ? bus.iaddr : bus.daddr;
      mbe_mux   = (iack || !bus.dwe) ? {BW{1'b1}} : bus.dbe;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg   <= LAST_I;
         locked_reg <= 1'b0;
      end else begin
         last_reg   <= last_next;
         locked_reg <= locked_next;
      end
   end

   arb_tag_pipe #(.LAT(LAT_EFF)) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign bus.iack   = iack;
   assign bus.dack   = dack;
   assign bus.men    = iack | dack;
   assign bus.mwe    = dack & bus.dwe;
   assign bus.mbe    = mbe_mux;
   assign bus.maddr  = maddr_mux;
   assign bus.mwdata = bus.dwdata;
   assign bus.owner  = dack ? OWN_D : (iack ? OWN_I : OWN_NONE);

   // Read data is broadcast to both ports; only the valid strobe is steered.
   assign bus.idata  = bus.mrdata;
   assign bus.drdata = bus.mrdata;
   assign bus.ivalid = ~rst & (tag_out == OWN_I);
   assign bus.dvalid = ~rst & (tag_out == OWN_D);

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: two instances (LAT=1 and LAT=3) share one
// stimulus stream; each keeps a queue of expected read returns.
module tb_mem_arbiter2;
   import mem_arbiter2_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      int due;
      bit is_i;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq, dreq, dwe, dlock;
   logic [31:0] iaddr, daddr, dwdata;
   logic [3:0]  dbe;
   logic        exp_iack, exp_dack;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int lat, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s lat=%0d observed=0x%0h expected=0x%0h cycle=%0d", tag, lat, obs, expv, cyc);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         localparam int L = (gi == 0) ? 1 : 3;
         mem_arbiter2_if #(.AW(AW), .DW(DW)) bus ();
         ev_t         q[$];
         ev_t         ev;
         logic        exp_iv, exp_dv;
         logic [31:0] rd_exp;

         assign bus.ireq   = ireq;
         assign bus.iaddr  = iaddr;
         assign bus.dreq   = dreq;
         assign bus.dwe    = dwe;
         assign bus.dbe    = dbe;
         assign bus.daddr  = daddr;
         assign bus.dwdata = dwdata;
         assign bus.dlock  = dlock;
         assign bus.mrdata = 32'hA500_0000 ^ 32'(cyc);

         mem_arbiter2 #(.AW(AW), .DW(DW), .LAT(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
         );

         always @(negedge clk) begin
            exp_iv = 1'b0;
            exp_dv = 1'b0;
            if (rst) q.delete();
            if (q.size() > 0 && q[0].due == cyc) begin
               ev     = q.pop_front();
               exp_iv = ev.is_i;
               exp_dv = !ev.is_i;
            end
            rd_exp = 32'hA500_0000 ^ 32'(cyc);
            chk("ivalid", L, 64'(bus.ivalid), 64'(exp_iv));
            chk("dvalid", L, 64'(bus.dvalid), 64'(exp_dv));
            if (exp_iv) chk("idata", L, 64'(bus.idata), 64'(rd_exp));
            if (exp_dv) chk("drdata", L, 64'(bus.drdata), 64'(rd_exp));

            chk("iack", L, 64'(bus.iack), 64'(exp_iack));
            chk("dack", L, 64'(bus.dack), 64'(exp_dack));
            chk("men", L, 64'(bus.men), 64'(exp_iack | exp_dack));
            chk("mwe", L, 64'(bus.mwe), 64'(exp_dack & dwe));
            chk("maddr", L, 64'(bus.maddr), 64'(exp_iack ? iaddr : daddr));
            chk("mbe", L, 64'(bus.mbe), 64'((exp_iack || !dwe) ? 4'hF : dbe));
            chk("owner", L, 64'(bus.owner), 64'(exp_dack ? 2'd2 : (exp_iack ? 2'd1 : 2'd0)));
            if (exp_dack && dwe) chk("mwdata", L, 64'(bus.mwdata), 64'(dwdata));

            if (exp_iack) q.push_back('{cyc + L, 1'b1});
            else if (exp_dack && !dwe) q.push_back('{cyc + L, 1'b0});
         end
      end
   endgenerate

   task automatic step(input bit i, input logic [31:0] ia, input bit d, input bit we,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                       input bit lk, input bit ei, input bit ed);
      ireq     = i;
      iaddr    = ia;
      dreq     = d;
      dwe      = we;
      dbe      = be;
      daddr    = da;
      dwdata   = wd;
      dlock    = lk;
      exp_iack = ei;
      exp_dack = ed;
      $display("step cyc=%0d ireq=%0b iaddr=%h dreq=%0b we=%0b be=%h daddr=%h lock=%0b rst=%0b exp_iack=%0b exp_dack=%0b",
               cyc, i, ia, d, we, be, da, lk, rst, ei, ed);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      rst      = 1'b1;
      ireq     = 1'b0;
      iaddr    = '0;
      dreq     = 1'b0;
      dwe      = 1'b0;
      dbe      = '0;
      daddr    = '0;
      dwdata   = '0;
      dlock    = 1'b0;
      exp_iack = 1'b0;
      exp_dack = 1'b0;
      @(posedge clk);
      #1;

      // Requests during reset must not be granted
      step(1, 32'h100, 1, 0, 4'hF, 32'h200, 32'h0, 0, 0, 0);
      step(1, 32'h100, 1, 0, 4'hF, 32'h200, 32'h0, 0, 0, 0);
      rst = 1'b0;

      // Lone instruction read
      step(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
      idle(1);

      // Continuous contention
      for (int k = 0; k < 6; k++) begin
         step(1, 32'h104, 1, 0, 4'hF, 32'h180, 32'h0, 0,
              RR && (k % 2 == 1), !(RR && (k % 2 == 1)));
      end

      // Partial write then an instruction read
      step(0, 32'h0, 1, 1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 0, 0, 1);
      step(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
      idle(4);

      // Back-to-back reads I, D, I
      step(1, 32'h108, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
      step(0, 32'h0, 1, 0, 4'hF, 32'h300, 32'h0, 0, 0, 1);
      step(1, 32'h10C, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
      idle(5);

      // Locked data read holds off fetch until the lock drops
      step(0, 32'h0, 1, 0, 4'hF, 32'h400, 32'h0, 1, 0, 1);
      for (int k = 0; k < 4; k++) step(1, 32'h110, 0, 0, 4'hF, 32'h400, 32'h0, 1, 0, 0);
      step(1, 32'h110, 0, 0, 4'hF, 32'h400, 32'h0, 0, 1, 0);

      // Lock release together with contention
      step(0, 32'h0, 1, 0, 4'hF, 32'h404, 32'h0, 1, 0, 1);
      step(1, 32'h114, 0, 0, 4'hF, 32'h404, 32'h0, 1, 0, 0);
      step(1, 32'h114, 1, 0, 4'hF, 32'h408, 32'h0, 0, RR, !RR);
      idle(5);

      // Reset right after a read transfer: no return may follow
      step(1, 32'h120, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(5);

      // After reset the data port wins the first contention
      step(1, 32'h124, 1, 0, 4'hF, 32'h500, 32'h0, 0, 0, 1);
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
